// File: rtl/fetchCtrlPkg.sv
// Fetch sequencer types.
// FSM state encoding for fetch_ctrl.
package fetchCtrlPkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state;

endpackage

// File: rtl/instMgmtPkg.sv
// Instruction-register management types.
// inst_sel picks hold / bubble / load for the instruction register.
package instMgmtPkg;

  typedef enum logic [1:0] {
    INST_OLD = 2'd0,
    INST_NOP = 2'd1,
    INST_MEM = 2'd2
  } inst_sel;

endpackage

// File: rtl/rysyPkg.sv
// rysyCore shared core constants.
// Register width and the canonical NOP encoding.
package rysyPkg;

  localparam int REG_LEN = 32;
  localparam logic [REG_LEN-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl.sv
// rysyCore instruction-fetch sequencer.
// Owns the PC, the imem handshake and the inst register select.
module fetch_ctrl
  import rysyPkg::*;
  import fetchCtrlPkg::*;
#(
  parameter logic [REG_LEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned        FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic [REG_LEN-1:0]   mem_addr,
  input  logic                 mem_ack,
  input  logic                 stall,
  input  logic                 jump,
  input  logic [REG_LEN-1:0]   jump_target,
  input  logic                 halt,
  output instMgmtPkg::inst_sel inst_sel,
  output logic [REG_LEN-1:0]   inst_pc,
  output logic                 inst_valid
);

  localparam int CW =
    (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES);

  fetch_state           r_state;
  fetch_state           w_state_nxt;
  logic [REG_LEN-1:0]   r_pc;
  logic [REG_LEN-1:0]   w_pc_nxt;
  logic [REG_LEN-1:0]   r_req_addr;
  logic [REG_LEN-1:0]   w_req_addr_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [REG_LEN-1:0]   r_inst_pc;
  logic [REG_LEN-1:0]   w_inst_pc_nxt;
  logic                 r_inst_valid;
  logic                 w_inst_valid_nxt;
  logic                 w_req;
  instMgmtPkg::inst_sel w_sel;
  logic [REG_LEN-1:0]   w_tgt;
  logic [REG_LEN-1:0]   w_pc_inc;
  logic                 w_c_jmp_wait;
  logic                 w_c_jmp_ack;
  logic                 w_c_halt;
  logic                 w_c_load;
  logic                 w_c_ack_stall;
  logic                 w_c_wait_stall;
  logic                 w_c_wait_idle;

  assign w_tgt =
    jump_target & {{(REG_LEN-2){1'b1}}, 2'b00};
  assign w_pc_inc = r_pc + REG_LEN'(4);

  assign w_c_jmp_wait   = jump & ~mem_ack;
  assign w_c_jmp_ack    = jump & mem_ack;
  assign w_c_halt       = ~jump & mem_ack & halt;
  assign w_c_load       = ~jump & mem_ack & ~halt & ~stall;
  assign w_c_ack_stall  = ~jump & mem_ack & ~halt & stall;
  assign w_c_wait_stall = ~jump & ~mem_ack & stall;
  assign w_c_wait_idle  = ~jump & ~mem_ack & ~stall;

  // Next-state, next-register and handshake/select decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_cnt_nxt        = r_cnt;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_valid_nxt = r_inst_valid;
    w_req            = 1'b0;
    w_sel            = instMgmtPkg::INST_NOP;
    unique case (r_state)
      FETCH: begin
        w_req = 1'b1;
        unique case (1'b1)
          w_c_jmp_wait: begin
            w_req_addr_nxt   = r_pc;
            w_pc_nxt         = w_tgt;
            w_inst_valid_nxt = 1'b0;
            w_state_nxt      = DRAIN;
          end
          w_c_jmp_ack: begin
            w_pc_nxt         = w_tgt;
            w_inst_valid_nxt = 1'b0;
            w_cnt_nxt        = CNT_INIT;
            if (FLUSH_CYCLES != 0)
              w_state_nxt = FLUSH;
          end
          w_c_halt: begin
            w_inst_valid_nxt = 1'b0;
            w_state_nxt      = HALT;
          end
          w_c_load: begin
            w_sel            = instMgmtPkg::INST_MEM;
            w_inst_pc_nxt    = r_pc;
            w_pc_nxt         = w_pc_inc;
            w_inst_valid_nxt = 1'b1;
          end
          w_c_ack_stall: begin
            w_sel = instMgmtPkg::INST_OLD;
          end
          w_c_wait_stall: begin
            w_sel = instMgmtPkg::INST_OLD;
          end
          w_c_wait_idle: begin
            w_inst_valid_nxt = 1'b0;
          end
          default: ;
        endcase
      end
      DRAIN: begin
        w_req            = 1'b1;
        w_inst_valid_nxt = 1'b0;
        if (jump)
          w_pc_nxt = w_tgt;
        if (mem_ack) begin
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = (FLUSH_CYCLES != 0) ? FLUSH : FETCH;
        end
      end
      FLUSH: begin
        w_inst_valid_nxt = 1'b0;
        if (jump) begin
          w_pc_nxt  = w_tgt;
          w_cnt_nxt = CNT_INIT;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt <= CW'(1))
            w_state_nxt = FETCH;
        end
      end
      HALT: begin
        w_inst_valid_nxt = 1'b0;
        if (jump)
          w_pc_nxt = w_tgt;
        if (!halt)
          w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
    if (rst) begin
      w_req = 1'b0;
      w_sel = instMgmtPkg::INST_NOP;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= FETCH;
    else
      r_state <= w_state_nxt;
  end

  // PC, pending address, flush count and inst register tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_cnt        <= '0;
      r_inst_pc    <= RESET_PC;
      r_inst_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
    end
  end

  assign mem_req    = w_req;
  assign mem_addr   = (r_state == DRAIN) ? r_req_addr : r_pc;
  assign inst_sel   = w_sel;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl.
// Two instances: FLUSH_CYCLES=2 (d0) and FLUSH_CYCLES=0 (d1).
module tb_fetch_ctrl;
  import instMgmtPkg::*;

  typedef struct {
    int          id;
    bit          d;
    logic        req;
    logic [31:0] addr;
    inst_sel     sel;
    logic [31:0] ipc;
    logic        iv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ack, stall, jump, halt;
  logic [31:0] tgt;

  logic        req0, req1, iv0, iv1;
  logic [31:0] addr0, addr1, ipc0, ipc1;
  inst_sel     sel0, sel1;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   step  = 0;

  logic        a_req, a_iv;
  logic [31:0] a_addr, a_ipc;
  inst_sel     a_sel;
  bit          bad;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst),
    .mem_req(req0), .mem_addr(addr0), .mem_ack(ack),
    .stall(stall), .jump(jump), .jump_target(tgt),
    .halt(halt), .inst_sel(sel0),
    .inst_pc(ipc0), .inst_valid(iv0)
  );

  fetch_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst),
    .mem_req(req1), .mem_addr(addr1), .mem_ack(ack),
    .stall(stall), .jump(jump), .jump_target(tgt),
    .halt(halt), .inst_sel(sel1),
    .inst_pc(ipc1), .inst_valid(iv1)
  );

  task automatic drv(input logic r, input logic a,
                     input logic s, input logic j,
                     input logic [31:0] t, input logic h);
    rst = r; ack = a; stall = s;
    jump = j; tgt = t; halt = h;
  endtask

  task automatic ex(input bit d, input logic rq,
                    input logic [31:0] ad, input inst_sel sl,
                    input logic [31:0] pc, input logic v);
    exp_t x;
    x.id = step; x.d = d; x.req = rq; x.addr = ad;
    x.sel = sl; x.ipc = pc; x.iv = v;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
  endtask

  // Monitor: pop every expectation issued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      a_req  = e.d ? req1  : req0;
      a_addr = e.d ? addr1 : addr0;
      a_sel  = e.d ? sel1  : sel0;
      a_ipc  = e.d ? ipc1  : ipc0;
      a_iv   = e.d ? iv1   : iv0;
      bad = (a_req !== e.req) ||
            (e.req && (a_addr !== e.addr)) ||
            (a_sel !== e.sel) ||
            (a_ipc !== e.ipc) ||
            (a_iv !== e.iv);
      n_vec++;
      if (bad) begin
        n_bad++;
        $display({"FAIL step%0d dut%0d: got req=%b addr=%h ",
                  "sel=%0d ipc=%h iv=%b, want req=%b addr=%h ",
                  "sel=%0d ipc=%h iv=%b"},
                 e.id, e.d, a_req, a_addr, a_sel, a_ipc, a_iv,
                 e.req, e.addr, e.sel, e.ipc, e.iv);
      end
    end
  end

  initial begin
    drv(1, 0, 0, 0, 0, 0);
    tick();
    // reset state
    ex(0, 0, 0, INST_NOP, 0, 0);
    ex(1, 0, 0, INST_NOP, 0, 0);
    tick();
    // sequential fetch
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h0, INST_MEM, 32'h0, 0);
    ex(1, 1, 32'h0, INST_MEM, 32'h0, 0);
    tick();
    ex(0, 1, 32'h4, INST_MEM, 32'h0, 1);
    tick();
    // stall with ack held
    drv(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ex(0, 1, 32'h8, INST_OLD, 32'h4, 1);
      tick();
    end
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h8, INST_MEM, 32'h4, 1);
    tick();
    ex(0, 1, 32'hC, INST_MEM, 32'h8, 1);
    tick();
    // jump with request in flight
    drv(0, 0, 0, 1, 32'h103, 0);
    ex(0, 1, 32'h10, INST_NOP, 32'hC, 1);
    ex(1, 1, 32'h10, INST_NOP, 32'hC, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 1, 32'h10, INST_NOP, 32'hC, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h10, INST_NOP, 32'hC, 0);
    ex(1, 1, 32'h10, INST_NOP, 32'hC, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 0, 32'h0, INST_NOP, 32'hC, 0);
    ex(1, 1, 32'h100, INST_NOP, 32'hC, 0);
    tick();
    ex(0, 0, 32'h0, INST_NOP, 32'hC, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h100, INST_MEM, 32'hC, 0);
    ex(1, 1, 32'h100, INST_MEM, 32'hC, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 1, 32'h104, INST_NOP, 32'h100, 1);
    tick();
    // halt waits for the in-flight ack
    drv(0, 0, 0, 0, 0, 1);
    ex(0, 1, 32'h104, INST_NOP, 32'h100, 0);
    tick();
    ex(0, 1, 32'h104, INST_NOP, 32'h100, 0);
    tick();
    drv(0, 1, 0, 0, 0, 1);
    ex(0, 1, 32'h104, INST_NOP, 32'h100, 0);
    tick();
    drv(0, 0, 0, 1, 32'h40, 1);
    ex(0, 0, 32'h0, INST_NOP, 32'h100, 0);
    tick();
    drv(0, 0, 0, 0, 0, 1);
    ex(0, 0, 32'h0, INST_NOP, 32'h100, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 0, 32'h0, INST_NOP, 32'h100, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h40, INST_MEM, 32'h100, 0);
    ex(1, 1, 32'h40, INST_MEM, 32'h100, 0);
    tick();
    drv(0, 0, 1, 0, 0, 0);
    ex(0, 1, 32'h44, INST_OLD, 32'h40, 1);
    tick();
    // reset while draining
    drv(0, 0, 0, 1, 32'h200, 0);
    ex(0, 1, 32'h44, INST_NOP, 32'h40, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 1, 32'h44, INST_NOP, 32'h40, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    ex(0, 0, 32'h0, INST_NOP, 32'h40, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 1, 32'h0, INST_NOP, 32'h0, 0);
    ex(1, 1, 32'h0, INST_NOP, 32'h0, 0);
    tick();
    // PC wrap at top of address space
    drv(0, 1, 0, 1, 32'hFFFF_FFFF, 0);
    ex(0, 1, 32'h0, INST_NOP, 32'h0, 0);
    ex(1, 1, 32'h0, INST_NOP, 32'h0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 0, 32'h0, INST_NOP, 32'h0, 0);
    ex(1, 1, 32'hFFFF_FFFC, INST_NOP, 32'h0, 0);
    tick();
    ex(0, 0, 32'h0, INST_NOP, 32'h0, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 1, 32'hFFFF_FFFC, INST_MEM, 32'h0, 0);
    ex(1, 1, 32'hFFFF_FFFC, INST_MEM, 32'h0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    ex(0, 1, 32'h0, INST_NOP, 32'hFFFF_FFFC, 1);
    ex(1, 1, 32'h0, INST_NOP, 32'hFFFF_FFFC, 1);
    tick();
    drv(1, 0, 0, 0, 0, 0);
    ex(0, 0, 32'h0, INST_NOP, 32'hFFFF_FFFC, 0);
    ex(1, 0, 32'h0, INST_NOP, 32'hFFFF_FFFC, 0);
    tick();
    // jump+ack with and without flush bubbles
    drv(0, 1, 0, 1, 32'h80, 0);
    ex(0, 1, 32'h0, INST_NOP, 32'h0, 0);
    ex(1, 1, 32'h0, INST_NOP, 32'h0, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    ex(0, 0, 32'h0, INST_NOP, 32'h0, 0);
    ex(1, 1, 32'h80, INST_MEM, 32'h0, 0);
    tick();
    ex(0, 0, 32'h0, INST_NOP, 32'h0, 0);
    ex(1, 1, 32'h84, INST_MEM, 32'h80, 1);
    tick();
    ex(0, 1, 32'h80, INST_MEM, 32'h0, 0);
    ex(1, 1, 32'h88, INST_MEM, 32'h84, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the rysyCore front end.
- Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Drives the instruction register's inst_sel (INST_OLD / INST_NOP / INST_MEM) every cycle, deciding whether the register holds, bubbles or loads the fetched word.
- Handles stalls, taken jumps (including one arriving with a memory request in flight), post-jump flush bubbles and halt/resume.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset.
- FLUSH_CYCLES, 2: NOP cycles inserted after a jump before fetching resumes. 0 means none.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request. Held with mem_addr stable until mem_ack.
- mem_addr  out  REG_LEN  fetch address, word aligned.
- mem_ack  in  1  rdata valid for mem_addr this cycle. Ends the transaction.
- stall  in  1  downstream cannot accept a new instruction.
- jump  in  1  taken branch/jump, one-cycle pulse.
- jump_target  in  REG_LEN  new PC. Bits [1:0] are ignored and treated as 0.
- halt  in  1  level: stop fetching.
- inst_sel  out  instMgmtPkg::inst_sel  combinational select to the instruction register.
- inst_pc  out  REG_LEN  PC of the word currently held in the instruction register.
- inst_valid  out  1  instruction register holds a real fetched instruction, not a NOP.

Behaviour:
- Reset (rst=1):
  - Outputs: mem_req=0, inst_sel=INST_NOP.
  - Next state: state=FETCH, pc=RESET_PC, req_addr=RESET_PC, inst_pc=RESET_PC, inst_valid=0, cnt=0.
  - rst overrides all other inputs in any state, including mid-transaction. The pending request is abandoned.
- States: FETCH, DRAIN, FLUSH, HALT.
- mem_addr = req_addr in DRAIN, pc otherwise.
- FETCH: mem_req=1. Priority order:
  1. jump & !mem_ack: req_addr<=pc, pc<=target, inst_sel=NOP, inst_valid<=0, go to DRAIN.
  2. jump & mem_ack: word discarded, pc<=target, inst_sel=NOP, inst_valid<=0, cnt<=FLUSH_CYCLES. Go to FLUSH, or stay in FETCH if FLUSH_CYCLES=0. Jump overrides stall.
  3. mem_ack & halt: word discarded, pc unchanged, inst_sel=NOP, inst_valid<=0, go to HALT. Without mem_ack, halt waits for the in-flight transaction.
  4. mem_ack & !stall: inst_sel=MEM, inst_pc<=pc, pc<=pc+4 (modulo 2^REG_LEN, so 32'hFFFF_FFFC wraps to 0), inst_valid<=1.
  5. mem_ack & stall: inst_sel=OLD, word discarded, pc unchanged. The same address is re-requested next cycle.
  6. !mem_ack & stall: inst_sel=OLD, inst_valid holds.
  7. !mem_ack & !stall: inst_sel=NOP, inst_valid<=0.
- DRAIN: mem_req=1 at req_addr, inst_sel=NOP.
  - A further jump updates pc; the latest target wins.
  - mem_ack: word discarded, cnt<=FLUSH_CYCLES. Go to FLUSH, or to FETCH if FLUSH_CYCLES=0.
- FLUSH: mem_req=0, inst_sel=NOP, inst_valid<=0.
  - cnt decrements each cycle. When cnt==1, go to FETCH.
  - A jump reloads pc and sets cnt<=FLUSH_CYCLES.
- HALT: mem_req=0, inst_sel=NOP, inst_valid<=0.
  - A jump updates pc and the block stays in HALT.
  - halt=0: go to FETCH next cycle.
- In DRAIN, FLUSH and HALT, stall is ignored.
- Latency: a word acked in cycle N appears in the instruction register, with inst_valid=1, after edge N+1.

Decomposition:
- Reuse rysyPkg (REG_LEN, NOP) and instMgmtPkg::inst_sel.
- Add the fetch_state enum {FETCH, DRAIN, FLUSH, HALT} to a new fetchCtrlPkg.
- Flush counter width: $clog2(FLUSH_CYCLES+1), minimum 1.
- No sub-module; a single FSM with registered pc, req_addr, cnt, inst_pc and inst_valid.

Test Plan:
1. Release reset, mem_ack tied 1, stall=0 -> mem_addr 0x0, 0x4, 0x8 on consecutive cycles. inst_sel=MEM each cycle; inst_pc follows one cycle later; inst_valid=1 from the second cycle.
2. stall=1 for 3 cycles while mem_ack=1 at addr 0x8 -> inst_sel=OLD for 3 cycles and mem_addr stays 0x8. After release, inst_pc=0x8 loaded once with no skip or duplicate.
3. mem_ack=0 at 0x10, then jump to 0x103 -> DRAIN, mem_addr stays 0x10 until ack. Then 2 NOP cycles, then mem_addr=0x100, with the 0x10 word never loaded.
4. FLUSH_CYCLES=0 with jump+mem_ack in the same cycle -> next cycle in FETCH with mem_addr=target and exactly one NOP inserted.
5. halt=1 with mem_ack delayed 2 cycles -> mem_req held until ack, then mem_req=0 and inst_valid=0. With halt=0 and a jump to 0x40 during HALT, fetch resumes at 0x40.
6. rst asserted in DRAIN, and separately pc=0xFFFF_FFFC with ack -> after reset mem_addr=RESET_PC and inst_valid=0; the wrap case yields next mem_addr=0x0.
